// File: rtl/maze_nav_ctrl.sv
// Button-driven navigator for a 3x3 maze: edge-detects the four direction buttons,
// rate-limits moves by frame count, and runs a blink/restart sequence once the goal is reached.
module maze_nav_ctrl #(
    parameter logic [5:0] H_OPEN       = 6'b111111,
    parameter logic [5:0] V_OPEN       = 6'b001100,
    parameter int         GOAL         = 8,
    parameter int         MOVE_GAP     = 4,
    parameter int         BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       frame_tick,
    output logic [3:0] pos,
    output logic       move_pulse,
    output logic       bump_pulse,
    output logic       win,
    output logic       blink,
    output logic [7:0] moves,
    output logic       state_dbg
);

    localparam int GW = (MOVE_GAP > 0) ? $clog2(MOVE_GAP + 1) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int TW = $clog2(2 * BLINK_FRAMES + 1);

    localparam logic [GW-1:0] GAP_MAX       = GW'(MOVE_GAP);
    localparam logic [BW-1:0] BLINK_LAST    = BW'(BLINK_FRAMES - 1);
    localparam logic [TW-1:0] RESTART_TICKS = TW'(2 * BLINK_FRAMES);
    localparam logic [3:0]    GOAL_POS      = 4'(GOAL);
    // Padded so a full 4-bit cell-derived index can select without range issues.
    localparam logic [15:0]   H_PAD         = {10'd0, H_OPEN};
    localparam logic [15:0]   V_PAD         = {10'd0, V_OPEN};

    typedef enum logic {PLAY = 1'b0, WIN = 1'b1} state_t;

    state_t          state, state_n;
    logic [3:0]      prev;
    logic [3:0]      btn;
    logic [3:0]      edges;
    logic [1:0]      row, col;
    logic [3:0]      hr_idx, hl_idx;
    logic            sel_valid;
    logic            sel_legal;
    logic [3:0]      sel_tgt;

    logic [3:0]      pos_n;
    logic [7:0]      moves_n;
    logic [GW-1:0]   gap, gap_n;
    logic [BW-1:0]   blink_cnt, blink_cnt_n;
    logic [TW-1:0]   win_ticks, win_ticks_n;
    logic            blink_n, move_n, bump_n;

    assign btn       = {btn_u, btn_d, btn_l, btn_r};
    assign edges     = btn & ~prev;
    assign sel_valid = |edges;
    assign win       = (state == WIN);
    assign state_dbg = state;

    always_comb begin
        row = 2'd2;
        col = 2'd2;
        case (pos)
            4'd0, 4'd1, 4'd2: row = 2'd0;
            4'd3, 4'd4, 4'd5: row = 2'd1;
            default:          row = 2'd2;
        endcase
        case (pos)
            4'd0, 4'd3, 4'd6: col = 2'd0;
            4'd1, 4'd4, 4'd7: col = 2'd1;
            default:          col = 2'd2;
        endcase
    end

    // Horizontal passage index is row*2+col, i.e. pos-row for the rightward wall.
    assign hr_idx = pos - {2'b00, row};
    assign hl_idx = hr_idx - 4'd1;

    // Single winner among simultaneous edges: up > down > left > right.
    always_comb begin
        sel_tgt   = pos;
        sel_legal = 1'b0;
        if (edges[3]) begin
            if (row != 2'd0) begin
                sel_tgt   = pos - 4'd3;
                sel_legal = V_PAD[pos - 4'd3];
            end
        end else if (edges[2]) begin
            if (row != 2'd2) begin
                sel_tgt   = pos + 4'd3;
                sel_legal = V_PAD[pos];
            end
        end else if (edges[1]) begin
            if (col != 2'd0) begin
                sel_tgt   = pos - 4'd1;
                sel_legal = H_PAD[hl_idx];
            end
        end else if (edges[0]) begin
            if (col != 2'd2) begin
                sel_tgt   = pos + 4'd1;
                sel_legal = H_PAD[hr_idx];
            end
        end
    end

    always_comb begin
        state_n     = state;
        pos_n       = pos;
        moves_n     = moves;
        gap_n       = gap;
        blink_n     = blink;
        blink_cnt_n = blink_cnt;
        win_ticks_n = win_ticks;
        move_n      = 1'b0;
        bump_n      = 1'b0;
        case (state)
            PLAY: begin
                if (frame_tick && gap != GAP_MAX) gap_n = gap + GW'(1);
                if (pos == GOAL_POS) begin
                    // Arrival cycle: enter WIN and let any coincident press go.
                    state_n     = WIN;
                    blink_n     = 1'b0;
                    blink_cnt_n = '0;
                    win_ticks_n = '0;
                end else if (sel_valid && gap == GAP_MAX) begin
                    if (sel_legal) begin
                        pos_n  = sel_tgt;
                        move_n = 1'b1;
                        gap_n  = '0;
                        if (moves != 8'hFF) moves_n = moves + 8'd1;
                    end else begin
                        bump_n = 1'b1;
                    end
                end
            end
            WIN: begin
                if (sel_valid && win_ticks == RESTART_TICKS) begin
                    state_n     = PLAY;
                    pos_n       = 4'd0;
                    moves_n     = 8'd0;
                    gap_n       = GAP_MAX;
                    blink_n     = 1'b0;
                    blink_cnt_n = '0;
                    win_ticks_n = '0;
                end else if (frame_tick) begin
                    if (win_ticks != RESTART_TICKS) win_ticks_n = win_ticks + TW'(1);
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt_n = '0;
                        blink_n     = ~blink;
                    end else begin
                        blink_cnt_n = blink_cnt + BW'(1);
                    end
                end
            end
            default: state_n = PLAY;
        endcase
    end

    // prev tracks the buttons even during reset so a held button yields no edge afterwards.
    always_ff @(posedge clk) begin
        prev <= btn;
        if (reset) begin
            state      <= PLAY;
            pos        <= 4'd0;
            moves      <= 8'd0;
            gap        <= GAP_MAX;
            blink      <= 1'b0;
            blink_cnt  <= '0;
            win_ticks  <= '0;
            move_pulse <= 1'b0;
            bump_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            moves      <= moves_n;
            gap        <= gap_n;
            blink      <= blink_n;
            blink_cnt  <= blink_cnt_n;
            win_ticks  <= win_ticks_n;
            move_pulse <= move_n;
            bump_pulse <= bump_n;
        end
    end

endmodule

// File: tb/tb_maze_nav_ctrl.sv
// Bench for maze_nav_ctrl: grid-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized button/frame traffic.
module tb_maze_nav_ctrl;

    localparam int MOVE_GAP = 4;
    localparam int BF       = 8;
    localparam int GOAL     = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_u, btn_d, btn_l, btn_r, frame_tick;
    logic [3:0] pos;
    logic       move_pulse, bump_pulse, win, blink;
    logic [7:0] moves;
    logic       state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] h_mask = 6'b111111;
    logic [5:0] v_mask = 6'b001100;

    // model state
    int         m_r, m_c, m_moves, m_since, m_wticks;
    bit         m_win, m_move, m_bump, m_blink;
    logic [3:0] m_prev;

    maze_nav_ctrl #(
        .H_OPEN(6'b111111), .V_OPEN(6'b001100), .GOAL(GOAL),
        .MOVE_GAP(MOVE_GAP), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .frame_tick(frame_tick),
        .pos(pos), .move_pulse(move_pulse), .bump_pulse(bump_pulse),
        .win(win), .blink(blink), .moves(moves), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit passage(input int r, input int c, input int nr, input int nc);
        if (nr < 0 || nr > 2 || nc < 0 || nc > 2) return 1'b0;
        if (nr == r) return h_mask[r * 2 + ((nc < c) ? nc : c)];
        return v_mask[((nr < r) ? nr : r) * 3 + c];
    endfunction

    task automatic model_step();
        logic [3:0] b, e;
        int dr, dc;
        bit ready;
        b = {btn_u, btn_d, btn_l, btn_r};
        if (reset) begin
            m_r = 0; m_c = 0; m_moves = 0; m_since = MOVE_GAP; m_wticks = 0;
            m_win = 0; m_move = 0; m_bump = 0;
            m_prev = b;
        end else begin
            e = b & ~m_prev;
            m_prev = b;
            m_move = 0;
            m_bump = 0;
            if (!m_win) begin
                ready = (m_since >= MOVE_GAP);
                if (frame_tick) m_since++;
                if (m_r * 3 + m_c == GOAL) begin
                    m_win = 1;
                    m_wticks = 0;
                end else if (e != 0 && ready) begin
                    if (e[3])      begin dr = -1; dc = 0;  end
                    else if (e[2]) begin dr = 1;  dc = 0;  end
                    else if (e[1]) begin dr = 0;  dc = -1; end
                    else           begin dr = 0;  dc = 1;  end
                    if (passage(m_r, m_c, m_r + dr, m_c + dc)) begin
                        m_r += dr;
                        m_c += dc;
                        m_moves = (m_moves < 255) ? m_moves + 1 : 255;
                        m_since = 0;
                        m_move = 1;
                    end else begin
                        m_bump = 1;
                    end
                end
            end else begin
                if (e != 0 && m_wticks >= 2 * BF) begin
                    m_win = 0; m_r = 0; m_c = 0; m_moves = 0;
                    m_since = MOVE_GAP; m_wticks = 0;
                end else if (frame_tick) begin
                    m_wticks++;
                end
            end
        end
        m_blink = m_win && (((m_wticks / BF) % 2) == 1);
    endtask

    // scoreboard: model stepped on every active edge, DUT compared 1 time unit later
    initial begin : compare
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("pos",   {4'd0, pos}, 8'(m_r * 3 + m_c));
            check("move",  {7'd0, move_pulse}, {7'd0, m_move});
            check("bump",  {7'd0, bump_pulse}, {7'd0, m_bump});
            check("win",   {7'd0, win},   {7'd0, m_win});
            check("blink", {7'd0, blink}, {7'd0, m_blink});
            check("moves", moves, 8'(m_moves));
        end
    end

    // driver tasks (all called from negedge context)
    task automatic clear_btns();
        btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0;
    endtask

    task automatic set_btn(input int d);
        case (d)
            3: btn_u = 1;
            2: btn_d = 1;
            1: btn_l = 1;
            default: btn_r = 1;
        endcase
    endtask

    task automatic press(input int d);
        @(negedge clk);
        set_btn(d);
        @(negedge clk);
        clear_btns();
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk);
            frame_tick = 1;
            @(negedge clk);
            frame_tick = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    // 3=up 2=down 1=left 0=right; path 0,1,2,5,4,3,6,7,8
    task automatic walk_to_goal();
        int path [8] = '{0, 0, 2, 1, 1, 2, 0, 0};
        for (int i = 0; i < 8; i++) begin
            if (i != 0) frames(MOVE_GAP);
            press(path[i]);
        end
    endtask

    initial begin : stimulus
        reset = 1; frame_tick = 0;
        clear_btns();
        btn_r = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        check("held_r_pos", {4'd0, pos}, 8'd0);
        check("held_r_moves", moves, 8'd0);
        check("held_r_pulse", {7'd0, move_pulse}, 8'd0);
        btn_r = 0;

        // rate limiting
        press(0);
        check("first_r_pos", {4'd0, pos}, 8'd1);
        check("first_r_pulse", {7'd0, move_pulse}, 8'd1);
        check("first_r_moves", moves, 8'd1);
        frames(2);
        press(0);
        check("early_r_pos", {4'd0, pos}, 8'd1);
        check("early_r_pulse", {7'd0, move_pulse}, 8'd0);
        check("early_r_bump", {7'd0, bump_pulse}, 8'd0);
        frames(4);
        press(0);
        check("late_r_pos", {4'd0, pos}, 8'd2);

        // walls and edges of the grid
        do_reset();
        press(3);
        check("offgrid_bump", {7'd0, bump_pulse}, 8'd1);
        check("offgrid_pos", {4'd0, pos}, 8'd0);
        press(0);
        frames(4);
        press(2);
        check("wall_bump", {7'd0, bump_pulse}, 8'd1);
        check("wall_pos", {4'd0, pos}, 8'd1);
        press(0);
        check("after_bump_pos", {4'd0, pos}, 8'd2);
        frames(4);
        press(2);
        check("open_down_pos", {4'd0, pos}, 8'd5);

        // simultaneous edges
        do_reset();
        @(negedge clk);
        btn_u = 1; btn_r = 1;
        @(negedge clk);
        check("prio_bump", {7'd0, bump_pulse}, 8'd1);
        check("prio_pos", {4'd0, pos}, 8'd0);
        clear_btns();

        // full walk, blink and restart
        do_reset();
        walk_to_goal();
        check("goal_pos", {4'd0, pos}, 8'd8);
        check("goal_moves", moves, 8'd8);
        check("goal_win_early", {7'd0, win}, 8'd0);
        @(negedge clk);
        check("goal_win", {7'd0, win}, 8'd1);
        check("win_blink0", {7'd0, blink}, 8'd0);
        frames(7);
        check("blink_t7", {7'd0, blink}, 8'd0);
        frames(1);
        check("blink_t8", {7'd0, blink}, 8'd1);
        frames(2);
        press(3);
        check("t10_win", {7'd0, win}, 8'd1);
        check("t10_pos", {4'd0, pos}, 8'd8);
        frames(5);
        press(3);
        check("t15_win", {7'd0, win}, 8'd1);
        frames(1);
        check("blink_t16", {7'd0, blink}, 8'd0);
        press(0);
        check("restart_pos", {4'd0, pos}, 8'd0);
        check("restart_moves", moves, 8'd0);
        check("restart_win", {7'd0, win}, 8'd0);
        press(0);
        check("post_restart_pos", {4'd0, pos}, 8'd1);

        // reset from WIN
        do_reset();
        walk_to_goal();
        frames(9);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("rst_win_pos", {4'd0, pos}, 8'd0);
        check("rst_win_win", {7'd0, win}, 8'd0);
        check("rst_win_blink", {7'd0, blink}, 8'd0);
        check("rst_win_moves", moves, 8'd0);
        check("rst_win_move", {7'd0, move_pulse}, 8'd0);
        check("rst_win_bump", {7'd0, bump_pulse}, 8'd0);
        reset = 0;

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 1499) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: btn_u = ~btn_u;
                    1: btn_d = ~btn_d;
                    2: btn_l = ~btn_l;
                    default: btn_r = ~btn_r;
                endcase
            end
        end
        @(negedge clk);
        reset = 0; frame_tick = 0;
        clear_btns();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
